// File: rtl/cpu_trace_buffer_if.sv
// Readout handshake for cpu_trace_buffer: the buffer is master, the debug reader is slave.
interface cpu_trace_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture for the SM510 core: {fetch pc, state} per instruction into a FIFO/ring.
// Define TRACE_TRIGGER_EN to enable the PC-match trigger (WAIT_TRIG); otherwise arm starts directly.
module cpu_trace_buffer #(
  parameter int unsigned PC_WIDTH      = 12,
  parameter int unsigned STATE_WIDTH   = 20,
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned STAGE_WIDTH   = 4,
  parameter int unsigned STAGE_LOAD_PC = 0,
  parameter int unsigned STAGE_DECODE  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_en,
  input  logic [STAGE_WIDTH-1:0]     stage,
  input  logic [PC_WIDTH-1:0]        pc,
  input  logic [STATE_WIDTH-1:0]     cpu_state,
  input  logic                       mode,
  input  logic                       arm,
  input  logic [PC_WIDTH-1:0]        trigger_pc,
  input  logic [$clog2(DEPTH):0]     post_count,
  cpu_trace_buffer_if.master         rd,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                dropped,
  output logic                       capturing,
  output logic                       done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = PC_WIDTH + STATE_WIDTH;
  localparam logic [STAGE_WIDTH-1:0] StageLoad   = STAGE_WIDTH'(STAGE_LOAD_PC);
  localparam logic [STAGE_WIDTH-1:0] StageDecode = STAGE_WIDTH'(STAGE_DECODE);

  typedef enum logic [2:0] {StIdle, StWaitTrig, StCapture, StPost, StDone} state_e;

  state_e              state_q;
  logic                pending_q;
  logic [PC_WIDTH-1:0] last_pc_q;
  logic                mode_q;
  logic [LW-1:0]       post_q;
  logic [LW-1:0]       remaining_q;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q;
  logic [15:0]         dropped_q;
  logic                capturing_q, done_q;
  logic [EW-1:0]       mem_q [DEPTH];

  logic pc_load, evt, match, full, pop, accept, push, drop;

  assign pc_load = clk_en && (stage == StageLoad);
  assign evt     = clk_en && (stage == StageDecode) && pending_q;
  assign full    = (level_q == LW'(DEPTH));
  assign pop     = (level_q != '0) && rd.out_ready && !arm;

`ifdef TRACE_TRIGGER_EN
  assign match = (last_pc_q == trigger_pc);
`else
  logic unused_trigger_pc;
  assign unused_trigger_pc = ^trigger_pc;
  assign match = 1'b0;
`endif

  always_comb begin
    accept = 1'b0;
    if (evt && !arm) begin
      unique case (state_q)
        StWaitTrig:        accept = mode_q || match;
        StCapture, StPost: accept = 1'b1;
        StIdle, StDone:    accept = 1'b0;
        default:           accept = 1'b0;
      endcase
    end
  end

  // Full without a pop: stream drops the new entry, ring overwrites the oldest.
  assign push = accept && (!full || pop || mode_q);
  assign drop = accept && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pending_q   <= 1'b0;
      last_pc_q   <= '0;
      mode_q      <= 1'b0;
      post_q      <= '0;
      remaining_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      dropped_q   <= '0;
      capturing_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (pc_load) begin
        last_pc_q <= pc;
        pending_q <= 1'b1;
      end else if (evt) begin
        pending_q <= 1'b0;
      end

      if (arm) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        level_q   <= '0;
        dropped_q <= '0;
        mode_q    <= mode;
        post_q    <= post_count;
`ifdef TRACE_TRIGGER_EN
        state_q     <= StWaitTrig;
        capturing_q <= 1'b1;
        done_q      <= 1'b0;
`else
        if (!mode) begin
          state_q     <= StCapture;
          capturing_q <= 1'b1;
          done_q      <= 1'b0;
        end else if (post_count == '0) begin
          state_q     <= StDone;
          capturing_q <= 1'b0;
          done_q      <= 1'b1;
        end else begin
          state_q     <= StPost;
          remaining_q <= post_count;
          capturing_q <= 1'b1;
          done_q      <= 1'b0;
        end
`endif
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop || (drop && mode_q)) rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop && !full) level_q <= level_q + 1'b1;
        else if (pop && !push)     level_q <= level_q - 1'b1;
        if (drop && (dropped_q != 16'hFFFF)) dropped_q <= dropped_q + 1'b1;

        unique case (state_q)
          StWaitTrig: begin
            if (accept && match) begin
              if (!mode_q) begin
                state_q <= StCapture;
              end else if (post_q == '0) begin
                state_q     <= StDone;
                capturing_q <= 1'b0;
                done_q      <= 1'b1;
              end else begin
                state_q     <= StPost;
                remaining_q <= post_q;
              end
            end
          end
          StPost: begin
            if (accept) begin
              remaining_q <= remaining_q - 1'b1;
              if (remaining_q == LW'(1)) begin
                state_q     <= StDone;
                capturing_q <= 1'b0;
                done_q      <= 1'b1;
              end
            end
          end
          StIdle, StCapture, StDone: ;
          default: ;
        endcase
      end
    end
  end

  // Storage needs no reset; contents are only visible while level is non-zero.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= {last_pc_q, cpu_state};
  end

  assign rd.out_valid = (level_q != '0);
  assign rd.out_data  = mem_q[rd_ptr_q];
  assign level        = level_q;
  assign dropped      = dropped_q;
  assign capturing    = capturing_q;
  assign done         = done_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: queue-based reference model plus directed scenarios.
module tb_cpu_trace_buffer;

  localparam int unsigned PW = 12;
  localparam int unsigned SW = 20;
  localparam int unsigned D  = 8;

  logic          clk = 1'b0;
  logic          reset, clk_en, mode, arm;
  logic [3:0]    stage;
  logic [PW-1:0] pc, trigger_pc;
  logic [SW-1:0] cpu_state;
  logic [3:0]    post_count;
  logic [3:0]    level;
  logic [15:0]   dropped;
  logic          capturing, done;

  cpu_trace_buffer_if #(.DATA_WIDTH(PW + SW)) rd_if ();

  cpu_trace_buffer #(
    .PC_WIDTH(PW), .STATE_WIDTH(SW), .DEPTH(D), .STAGE_WIDTH(4),
    .STAGE_LOAD_PC(0), .STAGE_DECODE(1)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .stage(stage), .pc(pc),
    .cpu_state(cpu_state), .mode(mode), .arm(arm), .trigger_pc(trigger_pc),
    .post_count(post_count), .rd(rd_if.master), .level(level), .dropped(dropped),
    .capturing(capturing), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: buffer as a queue, session as a phase
  // (0 idle, 1 waiting for trigger, 2 streaming, 3 post-trigger, 4 done).
  logic [31:0] mq[$];
  int          m_drop, m_phase, m_rem, m_post;
  bit          m_ring, m_pending;
  logic [PW-1:0] m_last;

  always @(posedge clk) begin
    bit ev, popm, take, hit;
    logic [31:0] ent;
    if (reset) begin
      mq.delete();
      m_drop = 0; m_phase = 0; m_rem = 0; m_post = 0;
      m_ring = 0; m_pending = 0; m_last = '0;
    end else begin
      ev   = clk_en && (stage == 4'd1) && m_pending;
      popm = (mq.size() != 0) && rd_if.out_ready && !arm;
      ent  = {m_last, cpu_state};
      hit  = (m_last == trigger_pc);
      if (clk_en && stage == 4'd0) begin
        m_last = pc; m_pending = 1;
      end else if (ev) begin
        m_pending = 0;
      end
      if (arm) begin
        mq.delete();
        m_drop = 0; m_ring = mode; m_post = int'(post_count);
`ifdef TRACE_TRIGGER_EN
        m_phase = 1;
`else
        if (!mode) m_phase = 2;
        else if (m_post == 0) m_phase = 4;
        else begin m_phase = 3; m_rem = m_post; end
`endif
      end else begin
`ifdef TRACE_TRIGGER_EN
        take = ev && (m_phase == 2 || m_phase == 3 || (m_phase == 1 && (m_ring || hit)));
`else
        take = ev && (m_phase == 2 || m_phase == 3);
`endif
        if (take) begin
          if (mq.size() == D && !popm) begin
            if (m_ring) begin void'(mq.pop_front()); mq.push_back(ent); end
            if (m_drop < 65535) m_drop++;
          end else begin
            if (popm) void'(mq.pop_front());
            mq.push_back(ent);
          end
          if (m_phase == 1 && hit) begin
            if (!m_ring) m_phase = 2;
            else if (m_post == 0) m_phase = 4;
            else begin m_phase = 3; m_rem = m_post; end
          end else if (m_phase == 3) begin
            m_rem--;
            if (m_rem == 0) m_phase = 4;
          end
        end else if (popm) begin
          void'(mq.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("level", 32'(level), 32'(mq.size()));
      chk("out_valid", 32'(rd_if.out_valid), 32'(mq.size() != 0));
      chk("dropped", 32'(dropped), 32'(m_drop));
      chk("capturing", 32'(capturing), 32'(m_phase >= 1 && m_phase <= 3));
      chk("done", 32'(done), 32'(m_phase == 4));
      if (mq.size() != 0) chk("out_data", rd_if.out_data, mq[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic core_event(input logic [PW-1:0] p, input logic rdy);
    clk_en = 1; stage = 4'd0; pc = p; step();
    stage = 4'd1; cpu_state = SW'(p) * 20'd3 + 20'd5; rd_if.out_ready = rdy; step();
    stage = 4'd2; clk_en = 0; rd_if.out_ready = 0;
  endtask

  task automatic do_arm(input logic m, input logic [3:0] pcnt, input logic [PW-1:0] tpc);
    mode = m; post_count = pcnt; trigger_pc = tpc; arm = 1; step(); arm = 0;
  endtask

  task automatic pop_check(input string name, input logic [PW-1:0] exp_pc);
    chk({name, "_valid"}, 32'(rd_if.out_valid), 32'd1);
    chk({name, "_pc"}, 32'(rd_if.out_data[PW+SW-1:SW]), 32'(exp_pc));
    rd_if.out_ready = 1; step(); rd_if.out_ready = 0;
  endtask

  initial begin
    reset = 1; clk_en = 0; stage = 4'd2; pc = '0; cpu_state = '0; mode = 0; arm = 0;
    trigger_pc = '0; post_count = '0; rd_if.out_ready = 0;
    step(); step();
    reset = 0; cmp_en = 1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(rd_if.out_valid), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    chk("rst_capturing", 32'(capturing), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Stream basic
    do_arm(1'b0, 4'd0, 12'h010);
    chk("arm_capturing", 32'(capturing), 32'd1);
    for (int i = 0; i < 5; i++) core_event(12'h00E + 12'(i), 1'b0);
    chk("basic_dropped", 32'(dropped), 32'd0);
`ifdef TRACE_TRIGGER_EN
    chk("basic_level", 32'(level), 32'd3);
    for (int i = 0; i < 3; i++) pop_check("basic_entry", 12'h010 + 12'(i));
`else
    chk("basic_level", 32'(level), 32'd5);
    for (int i = 0; i < 5; i++) pop_check("basic_entry", 12'h00E + 12'(i));
`endif
    chk("basic_empty", 32'(rd_if.out_valid), 32'd0);

    // Stream overflow, then push+pop while full
    do_arm(1'b0, 4'd0, 12'h010);
    for (int i = 0; i < 12; i++) core_event(12'h010 + 12'(i), 1'b0);
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_dropped", 32'(dropped), 32'd4);
    chk("ovf_head", 32'(rd_if.out_data[PW+SW-1:SW]), 32'h010);
    core_event(12'h030, 1'b1);
    chk("pp_level", 32'(level), 32'd8);
    chk("pp_dropped", 32'(dropped), 32'd4);
    chk("pp_head", 32'(rd_if.out_data[PW+SW-1:SW]), 32'h011);

    // Ring + post-trigger
    do_arm(1'b1, 4'd2, 12'h109);
    for (int i = 0; i < 11; i++) core_event(12'h100 + 12'(i), 1'b0);
`ifdef TRACE_TRIGGER_EN
    chk("ring_not_done", 32'(done), 32'd0);
`endif
    core_event(12'h10B, 1'b0);
    chk("ring_done", 32'(done), 32'd1);
`ifdef TRACE_TRIGGER_EN
    chk("ring_level", 32'(level), 32'd8);
    chk("ring_dropped", 32'(dropped), 32'd4);
    for (int i = 0; i < 8; i++) pop_check("ring_entry", 12'h104 + 12'(i));
`else
    chk("ring_level", 32'(level), 32'd2);
    chk("ring_dropped", 32'(dropped), 32'd0);
    for (int i = 0; i < 2; i++) pop_check("ring_entry", 12'h100 + 12'(i));
`endif

    // Ring overwrite across the wrap
    do_arm(1'b1, 4'd10, 12'h400);
    for (int i = 0; i < 10; i++) core_event(12'h400 + 12'(i), 1'b0);
    chk("wrap_level", 32'(level), 32'd8);
    chk("wrap_dropped", 32'(dropped), 32'd2);
    chk("wrap_head", 32'(rd_if.out_data[PW+SW-1:SW]), 32'h402);
`ifdef TRACE_TRIGGER_EN
    chk("wrap_done", 32'(done), 32'd0);
`else
    chk("wrap_done", 32'(done), 32'd1);
`endif

    // Long DECODE stall yields one entry
    do_arm(1'b0, 4'd0, 12'h200);
    clk_en = 1; stage = 4'd0; pc = 12'h200; step();
    stage = 4'd1; cpu_state = 20'h12345;
    for (int i = 0; i < 10; i++) begin clk_en = (i % 2 == 0); step(); end
    stage = 4'd2; clk_en = 0; step();
    chk("stall_level", 32'(level), 32'd1);
    chk("stall_entry", rd_if.out_data, {12'h200, 20'h12345});

    // Arm coincident with an event
    clk_en = 1; stage = 4'd0; pc = 12'h201; step();
    stage = 4'd1; mode = 0; arm = 1; step();
    arm = 0; stage = 4'd2; clk_en = 0; step();
    chk("armcoll_level", 32'(level), 32'd0);

    // Ring with post_count=3, five events
    do_arm(1'b1, 4'd3, 12'h500);
    for (int i = 0; i < 5; i++) core_event(12'h500 + 12'(i), 1'b0);
    chk("post3_done", 32'(done), 32'd1);
`ifdef TRACE_TRIGGER_EN
    chk("post3_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) pop_check("post3_entry", 12'h500 + 12'(i));
`else
    chk("post3_level", 32'(level), 32'd3);
    for (int i = 0; i < 3; i++) pop_check("post3_entry", 12'h500 + 12'(i));
`endif

    // Reset during POST
    do_arm(1'b1, 4'd3, 12'h600);
    core_event(12'h600, 1'b0);
    core_event(12'h601, 1'b0);
    chk("post_capturing", 32'(capturing), 32'd1);
    reset = 1; step(); reset = 0;
    chk("rst2_level", 32'(level), 32'd0);
    chk("rst2_valid", 32'(rd_if.out_valid), 32'd0);
    chk("rst2_dropped", 32'(dropped), 32'd0);
    chk("rst2_capturing", 32'(capturing), 32'd0);
    chk("rst2_done", 32'(done), 32'd0);
    core_event(12'h602, 1'b0);
    chk("idle_ignores", 32'(level), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
